cp0_exc_sequencer: RTL and testbench
====================================

Name: cp0_exc_sequencer

Overview:
- MEM-stage exception unit directly upstream of the CP0 register file.
- Detects interrupts, synchronous exceptions and ERET for the instruction in MEM, using live Status/Cause/EPC with WB forwarding.
- Owns CP0's single write port and muxes pipeline MTC0 writes with its own multi-cycle entry/return write sequence.
- Issues the pipeline flush and the redirect PC.

Parameters:
- EXC_VECTOR, 32'h00000020, exception entry PC.
- EXL_BIT, 1, Status.EXL bit index; IE is bit 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_valid_i  in  1  MEM holds a real instruction
- mem_exc_i  in  32  flags: [8] syscall, [9] reserved instr, [10] trap, [11] overflow, [12] eret
- mem_pc_i  in  32  MEM instruction address
- mem_in_ds_i  in  1  MEM instruction is in a delay slot
- cp0_status_i / cp0_cause_i / cp0_epc_i  in  32 each  current CP0 values
- wb_cp0_we_i  in  1  MTC0 write request from WB
- wb_cp0_waddr_i  in  5  MTC0 target register
- wb_cp0_data_i  in  32  MTC0 data
- cp0_we_o / cp0_waddr_o / cp0_data_o  out  1/5/32  CP0 write port
- flush_o  out  1  one-cycle pipeline flush
- new_pc_o  out  32  redirect PC, valid while flush_o is high
- stall_o  out  1  sequence in progress
- exc_code_o  out  5  registered Cause.ExcCode shadow
- exc_bd_o  out  1  registered Cause.BD shadow

Behaviour:
- Forwarding:
  - status_f = wb write to reg 12 this cycle ? wb data : cp0_status_i.
  - epc_f = wb write to reg 14 this cycle ? wb data : cp0_epc_i.
- Interrupt pending (int_p) = (cp0_cause_i[15:10] & status_f[15:10]) != 0, and status_f[0] = 1, and status_f[EXL_BIT] = 0.
- Detection happens only in IDLE with mem_valid_i = 1. Priority and ExcCode:
  1. int_p → 5'h00
  2. bit9 → 5'h0a
  3. bit8 → 5'h08
  4. bit10 → 5'h0d
  5. bit11 → 5'h0c
  6. bit12 (ERET), lowest
- EPC value = mem_in_ds_i ? mem_pc_i - 4 : mem_pc_i (32-bit wrap).
- FSM states: IDLE, ENT_EPC, ENT_STAT, RET_STAT.
  - IDLE: write port passes the wb_cp0_* inputs straight through. On an exception → ENT_EPC; latch epc value, status_f, ExcCode; exc_bd_o <= mem_in_ds_i. On ERET → RET_STAT; latch status_f and epc_f.
  - ENT_EPC: write reg 14 = latched EPC; flush_o = 1; new_pc_o = EXC_VECTOR; → ENT_STAT.
  - ENT_STAT: write reg 12 = latched status with EXL set; → IDLE.
  - RET_STAT: write reg 12 = latched status with EXL cleared; flush_o = 1; new_pc_o = latched epc_f; → IDLE.
- stall_o = (state != IDLE).
- wb_cp0_* inputs are ignored outside IDLE; the pipeline is flushed, so they are never valid there.
- A WB MTC0 in the detection cycle is written that cycle, and its value is the one captured via forwarding.
- flush_o is high for exactly one cycle per event. An exception takes 2 cycles, an ERET 1.
- Reset (also mid-sequence) → IDLE. All outputs read 0: cp0_we_o, flush_o, stall_o, new_pc_o, exc_code_o, exc_bd_o.

Optional Feature:
- Macro: EXC_BEV_VECTOR_EN.
- Defined: entry new_pc_o = latched status[22] (BEV) ? 32'hBFC00380 : EXC_VECTOR.
- Undefined: entry new_pc_o is always EXC_VECTOR and status[22] is ignored.

Test Plan:
- mem_exc_i = 32'h100, mem_pc_i = 32'h40, status = 32'h10000000 → next cycle: cp0 write reg 14 = 32'h40, flush_o = 1, new_pc_o = 32'h20; following cycle: write reg 12 = 32'h10000002; exc_code_o = 5'h08.
- Same as above with mem_in_ds_i = 1 → EPC written = 32'h3C, exc_bd_o = 1.
- status = 32'h10000401, cause[10] = 1, mem_exc_i = 32'h200 → interrupt wins, exc_code_o = 0; repeat with status EXL = 1 → RI taken, exc_code_o = 5'h0a.
- ERET at detection with a WB MTC0 writing EPC = 32'h100 the same cycle → flush_o = 1, new_pc_o = 32'h100, Status written with EXL cleared, back in IDLE after 1 cycle.
- rst asserted during ENT_EPC → next cycle IDLE, no Status write issued, all outputs 0.
- EXC_BEV_VECTOR_EN defined, status[22] = 1, overflow (bit11) → new_pc_o = 32'hBFC00380, exc_code_o = 5'h0c.

Source files
------------

// File: rtl/cp0_exc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cp0_exc_sequencer                                            |
// | Description : MEM-stage exception/interrupt/ERET sequencer owning the CP0  |
// |               write port; optional macro EXC_BEV_VECTOR_EN selects the     |
// |               BEV boot-time exception vector.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cp0_exc_sequencer #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int          EXL_BIT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_exc_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_ds_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic        cp0_we_o,
    output logic [4:0]  cp0_waddr_o,
    output logic [31:0] cp0_data_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        stall_o,
    output logic [4:0]  exc_code_o,
    output logic        exc_bd_o
);

    localparam logic [4:0]  c_REG_STATUS = 5'd12;
    localparam logic [4:0]  c_REG_EPC    = 5'd14;
    localparam logic [31:0] c_BEV_VECTOR = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ENT_EPC  = 2'd1,
        S_ENT_STAT = 2'd2,
        S_RET_STAT = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_epc;
    logic [31:0] r_status;
    logic        r_flush;
    logic [31:0] r_new_pc;
    logic        r_stall;
    logic [4:0]  r_exc_code;
    logic        r_exc_bd;

    logic [31:0] w_status_f;
    logic [31:0] w_epc_f;
    logic        w_int_p;
    logic        w_any_exc;
    logic        w_take_exc;
    logic        w_take_eret;
    logic [4:0]  w_code;
    logic [31:0] w_epc_val;
    logic [31:0] w_entry_pc;

    // Same-cycle WB MTC0 must be visible to detection and to the captured copies.
    assign w_status_f = (wb_cp0_we_i && wb_cp0_waddr_i == c_REG_STATUS) ? wb_cp0_data_i : cp0_status_i;
    assign w_epc_f    = (wb_cp0_we_i && wb_cp0_waddr_i == c_REG_EPC)    ? wb_cp0_data_i : cp0_epc_i;

    assign w_int_p = ((cp0_cause_i[15:10] & w_status_f[15:10]) != 6'd0)
                     && w_status_f[0] && !w_status_f[EXL_BIT];

    assign w_any_exc   = w_int_p || (mem_exc_i[11:8] != 4'd0);
    assign w_take_exc  = (r_state == S_IDLE) && mem_valid_i && w_any_exc;
    assign w_take_eret = (r_state == S_IDLE) && mem_valid_i && !w_any_exc && mem_exc_i[12];
    assign w_epc_val   = mem_in_ds_i ? (mem_pc_i - 32'd4) : mem_pc_i;

    always_comb begin
        w_code = 5'h00;
        if (w_int_p)           w_code = 5'h00;
        else if (mem_exc_i[9]) w_code = 5'h0a;
        else if (mem_exc_i[8]) w_code = 5'h08;
        else if (mem_exc_i[10]) w_code = 5'h0d;
        else if (mem_exc_i[11]) w_code = 5'h0c;
    end

`ifdef EXC_BEV_VECTOR_EN
    assign w_entry_pc = w_status_f[22] ? c_BEV_VECTOR : EXC_VECTOR;
`else
    assign w_entry_pc = EXC_VECTOR;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_epc      <= 32'd0;
            r_status   <= 32'd0;
            r_flush    <= 1'b0;
            r_new_pc   <= 32'd0;
            r_stall    <= 1'b0;
            r_exc_code <= 5'd0;
            r_exc_bd   <= 1'b0;
        end else begin
            r_flush  <= 1'b0;
            r_new_pc <= 32'd0;
            case (r_state)
                S_IDLE: begin
                    if (w_take_exc) begin
                        r_state    <= S_ENT_EPC;
                        r_epc      <= w_epc_val;
                        r_status   <= w_status_f;
                        r_exc_code <= w_code;
                        r_exc_bd   <= mem_in_ds_i;
                        r_flush    <= 1'b1;
                        r_new_pc   <= w_entry_pc;
                        r_stall    <= 1'b1;
                    end else if (w_take_eret) begin
                        r_state  <= S_RET_STAT;
                        r_status <= w_status_f;
                        r_flush  <= 1'b1;
                        r_new_pc <= w_epc_f;
                        r_stall  <= 1'b1;
                    end
                end
                S_ENT_EPC: r_state <= S_ENT_STAT;
                S_ENT_STAT: begin
                    r_state <= S_IDLE;
                    r_stall <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    // The pipeline is flushed while sequencing, so WB writes only pass in IDLE.
    always_comb begin
        cp0_we_o    = 1'b0;
        cp0_waddr_o = 5'd0;
        cp0_data_o  = 32'd0;
        case (r_state)
            S_IDLE: begin
                cp0_we_o    = wb_cp0_we_i;
                cp0_waddr_o = wb_cp0_waddr_i;
                cp0_data_o  = wb_cp0_data_i;
            end
            S_ENT_EPC: begin
                cp0_we_o    = 1'b1;
                cp0_waddr_o = c_REG_EPC;
                cp0_data_o  = r_epc;
            end
            S_ENT_STAT: begin
                cp0_we_o             = 1'b1;
                cp0_waddr_o          = c_REG_STATUS;
                cp0_data_o           = r_status;
                cp0_data_o[EXL_BIT]  = 1'b1;
            end
            default: begin
                cp0_we_o             = 1'b1;
                cp0_waddr_o          = c_REG_STATUS;
                cp0_data_o           = r_status;
                cp0_data_o[EXL_BIT]  = 1'b0;
            end
        endcase
    end

    assign flush_o    = r_flush;
    assign new_pc_o   = r_new_pc;
    assign stall_o    = r_stall;
    assign exc_code_o = r_exc_code;
    assign exc_bd_o   = r_exc_bd;

    logic w_unused;
    assign w_unused = ^{mem_exc_i[31:13], mem_exc_i[7:0], cp0_cause_i[31:16], cp0_cause_i[9:0]};

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cp0_exc_sequencer                                         |
// | Description : Directed self-checking bench for cp0_exc_sequencer.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cp0_exc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic [31:0] mem_exc_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_ds_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic        cp0_we_o;
    logic [4:0]  cp0_waddr_o;
    logic [31:0] cp0_data_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        stall_o;
    logic [4:0]  exc_code_o;
    logic        exc_bd_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cp0_exc_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid_i    (mem_valid_i),
        .mem_exc_i      (mem_exc_i),
        .mem_pc_i       (mem_pc_i),
        .mem_in_ds_i    (mem_in_ds_i),
        .cp0_status_i   (cp0_status_i),
        .cp0_cause_i    (cp0_cause_i),
        .cp0_epc_i      (cp0_epc_i),
        .wb_cp0_we_i    (wb_cp0_we_i),
        .wb_cp0_waddr_i (wb_cp0_waddr_i),
        .wb_cp0_data_i  (wb_cp0_data_i),
        .cp0_we_o       (cp0_we_o),
        .cp0_waddr_o    (cp0_waddr_o),
        .cp0_data_o     (cp0_data_o),
        .flush_o        (flush_o),
        .new_pc_o       (new_pc_o),
        .stall_o        (stall_o),
        .exc_code_o     (exc_code_o),
        .exc_bd_o       (exc_bd_o)
    );

    task automatic idle_inputs();
        mem_valid_i    = 1'b0;
        mem_exc_i      = 32'd0;
        mem_pc_i       = 32'd0;
        mem_in_ds_i    = 1'b0;
        cp0_status_i   = 32'd0;
        cp0_cause_i    = 32'd0;
        cp0_epc_i      = 32'd0;
        wb_cp0_we_i    = 1'b0;
        wb_cp0_waddr_i = 5'd0;
        wb_cp0_data_i  = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        n_tests++;
        if ({cp0_we_o, flush_o, stall_o, new_pc_o, exc_code_o, exc_bd_o} !== 41'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: we=%b flush=%b stall=%b pc=%h code=%h bd=%b, expected all 0",
                     cp0_we_o, flush_o, stall_o, new_pc_o, exc_code_o, exc_bd_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_syscall(input logic ds, input logic [31:0] exp_epc);
        mem_valid_i  = 1'b1;
        mem_exc_i    = 32'h100;
        mem_pc_i     = 32'h40;
        mem_in_ds_i  = ds;
        cp0_status_i = 32'h1000_0000;
        tick();
        idle_inputs();
        n_tests++;
        if ({cp0_we_o, cp0_waddr_o, cp0_data_o} !== {1'b1, 5'd14, exp_epc}) begin
            n_fail++;
            $display("FAIL sys_epc_write(ds=%b): we=%b addr=%0d data=%h, expected 1/14/%h",
                     ds, cp0_we_o, cp0_waddr_o, cp0_data_o, exp_epc);
        end
        n_tests++;
        if ({flush_o, new_pc_o, stall_o, exc_code_o, exc_bd_o} !== {1'b1, 32'h20, 1'b1, 5'h08, ds}) begin
            n_fail++;
            $display("FAIL sys_entry(ds=%b): flush=%b pc=%h stall=%b code=%h bd=%b, expected 1/00000020/1/08/%b",
                     ds, flush_o, new_pc_o, stall_o, exc_code_o, exc_bd_o, ds);
        end
        tick();
        n_tests++;
        if ({cp0_we_o, cp0_waddr_o, cp0_data_o, flush_o, stall_o} !== {1'b1, 5'd12, 32'h1000_0002, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL sys_status_write: we=%b addr=%0d data=%h flush=%b stall=%b, expected 1/12/10000002/0/1",
                     cp0_we_o, cp0_waddr_o, cp0_data_o, flush_o, stall_o);
        end
        tick();
        n_tests++;
        if ({cp0_we_o, flush_o, stall_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL sys_back_idle: we=%b flush=%b stall=%b, expected 0/0/0", cp0_we_o, flush_o, stall_o);
        end
    endtask

    // Drives one detection cycle and checks the selected ExcCode, then drains the entry sequence.
    task automatic test_interrupt();
        logic [31:0] stat_tab [2] = '{32'h1000_0401, 32'h1000_0403};
        logic [4:0]  code_tab [2] = '{5'h00, 5'h0a};
        for (int i = 0; i < 2; i++) begin
            mem_valid_i  = 1'b1;
            mem_exc_i    = 32'h200;
            mem_pc_i     = 32'h80;
            cp0_status_i = stat_tab[i];
            cp0_cause_i  = 32'h0000_0400;
            tick();
            idle_inputs();
            n_tests++;
            if ({exc_code_o, flush_o} !== {code_tab[i], 1'b1}) begin
                n_fail++;
                $display("FAIL interrupt[%0d]: code=%h flush=%b, expected %h/1", i, exc_code_o, flush_o, code_tab[i]);
            end
            tick();
            tick();
        end
    endtask

    task automatic test_priority();
        logic [31:0] exc_tab  [5] = '{32'h700, 32'h500, 32'hC00, 32'h1800, 32'h1100};
        logic [4:0]  code_tab [5] = '{5'h0a, 5'h08, 5'h0d, 5'h0c, 5'h08};
        for (int i = 0; i < 5; i++) begin
            mem_valid_i = 1'b1;
            mem_exc_i   = exc_tab[i];
            mem_pc_i    = 32'h100;
            tick();
            idle_inputs();
            n_tests++;
            if ({exc_code_o, cp0_waddr_o, new_pc_o} !== {code_tab[i], 5'd14, 32'h20}) begin
                n_fail++;
                $display("FAIL priority[%0d]: code=%h addr=%0d pc=%h, expected %h/14/00000020",
                         i, exc_code_o, cp0_waddr_o, new_pc_o, code_tab[i]);
            end
            tick();
            tick();
        end
    endtask

    task automatic test_no_valid();
        mem_valid_i = 1'b0;
        mem_exc_i   = 32'h100;
        tick();
        idle_inputs();
        n_tests++;
        if ({flush_o, stall_o, cp0_we_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL no_valid: flush=%b stall=%b we=%b, expected 0/0/0", flush_o, stall_o, cp0_we_o);
        end
    endtask

    task automatic test_eret_fwd();
        mem_valid_i    = 1'b1;
        mem_exc_i      = 32'h1000;
        mem_pc_i       = 32'h300;
        cp0_status_i   = 32'h0000_0003;
        cp0_epc_i      = 32'h200;
        wb_cp0_we_i    = 1'b1;
        wb_cp0_waddr_i = 5'd14;
        wb_cp0_data_i  = 32'h100;
        #1;
        n_tests++;
        if ({cp0_we_o, cp0_waddr_o, cp0_data_o} !== {1'b1, 5'd14, 32'h100}) begin
            n_fail++;
            $display("FAIL eret_wb_passthru: we=%b addr=%0d data=%h, expected 1/14/00000100",
                     cp0_we_o, cp0_waddr_o, cp0_data_o);
        end
        tick();
        idle_inputs();
        n_tests++;
        if ({flush_o, new_pc_o, stall_o} !== {1'b1, 32'h100, 1'b1}) begin
            n_fail++;
            $display("FAIL eret_redirect: flush=%b pc=%h stall=%b, expected 1/00000100/1", flush_o, new_pc_o, stall_o);
        end
        n_tests++;
        if ({cp0_we_o, cp0_waddr_o, cp0_data_o} !== {1'b1, 5'd12, 32'h1}) begin
            n_fail++;
            $display("FAIL eret_status_write: we=%b addr=%0d data=%h, expected 1/12/00000001",
                     cp0_we_o, cp0_waddr_o, cp0_data_o);
        end
        tick();
        n_tests++;
        if ({flush_o, stall_o, cp0_we_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL eret_back_idle: flush=%b stall=%b we=%b, expected 0/0/0", flush_o, stall_o, cp0_we_o);
        end
    endtask

    task automatic test_reset_mid();
        mem_valid_i  = 1'b1;
        mem_exc_i    = 32'h100;
        mem_pc_i     = 32'h40;
        mem_in_ds_i  = 1'b1;
        cp0_status_i = 32'h1000_0000;
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        n_tests++;
        if ({cp0_we_o, flush_o, stall_o, new_pc_o, exc_code_o, exc_bd_o} !== 41'd0) begin
            n_fail++;
            $display("FAIL reset_mid: we=%b flush=%b stall=%b pc=%h code=%h bd=%b, expected all 0",
                     cp0_we_o, flush_o, stall_o, new_pc_o, exc_code_o, exc_bd_o);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if ({cp0_we_o, stall_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_no_status: we=%b stall=%b, expected 0/0", cp0_we_o, stall_o);
        end
    endtask

    task automatic test_bev();
        logic [31:0] exp_pc;
`ifdef EXC_BEV_VECTOR_EN
        exp_pc = 32'hBFC0_0380;
`else
        exp_pc = 32'h0000_0020;
`endif
        mem_valid_i  = 1'b1;
        mem_exc_i    = 32'h800;
        mem_pc_i     = 32'h500;
        cp0_status_i = 32'h0040_0000;
        tick();
        idle_inputs();
        n_tests++;
        if ({flush_o, new_pc_o, exc_code_o} !== {1'b1, exp_pc, 5'h0c}) begin
            n_fail++;
            $display("FAIL bev_vector: flush=%b pc=%h code=%h, expected 1/%h/0c", flush_o, new_pc_o, exc_code_o, exp_pc);
        end
        tick();
        n_tests++;
        if (cp0_data_o !== 32'h0040_0002) begin
            n_fail++;
            $display("FAIL bev_status_write: data=%h, expected 00400002", cp0_data_o);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_syscall(1'b0, 32'h40);
        test_syscall(1'b1, 32'h3C);
        test_interrupt();
        test_priority();
        test_no_valid();
        test_eret_fwd();
        test_reset_mid();
        test_bev();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
